// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - writeback port arbiter for the 32x32 register file with pending-write scoreboard
// Optional feature macro: WB_RR_ARB_EN (round-robin arbitration between A and B; default is fixed priority with starvation guard)
module wb_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [4:0]       a_wn,
  input  logic [31:0]      a_wd,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_wn,
  input  logic [31:0]      b_wd,
  input  logic             iss_valid,
  input  logic [4:0]       iss_wn,
  input  logic             flush,
  output logic             RegWrite,
  output logic [4:0]       WN,
  output logic [31:0]      WD,
  output logic [31:0]      busy_vec,
  output logic [CNT_W-1:0] starve_cnt
);

  logic        grant_a;
  logic        grant_b;
  logic        win;
  logic [4:0]  wn_sel;
  logic [31:0] wd_sel;
  logic [31:0] busy_next;

`ifdef WB_RR_ARB_EN
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_e;
  req_e rr_last;

  // Grant selection: single requester wins, contention goes to whoever was not granted last
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n && !flush) begin
      if (a_valid && b_valid) begin
        if (rr_last == REQ_A) grant_b = 1'b1;
        else                  grant_a = 1'b1;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  // Remember the most recent grant so contention alternates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= REQ_B;
    end else if (grant_a) begin
      rr_last <= REQ_A;
    end else if (grant_b) begin
      rr_last <= REQ_B;
    end
  end

  assign starve_cnt = '0;
`else
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // Grant selection: A has priority unless B has waited STARVE_LIM cycles
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n && !flush) begin
      if (b_valid && (!a_valid || starve_cnt == STARVE_LIM)) grant_b = 1'b1;
      else                                                   grant_a = a_valid;
    end
  end

  // Count consecutive cycles B is left waiting; saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (flush) begin
      starve_cnt <= '0;
    end else if (b_valid && !grant_b) begin
      if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end
`endif

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign win     = grant_a | grant_b;
  assign wn_sel  = grant_b ? b_wn : a_wn;
  assign wd_sel  = grant_b ? b_wd : a_wd;

  // Register the winning write; writes to r0 are accepted but dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite <= 1'b0;
      WN       <= '0;
      WD       <= '0;
    end else begin
      RegWrite <= win && (wn_sel != 5'd0);
      if (win && (wn_sel != 5'd0)) begin
        WN <= wn_sel;
        WD <= wd_sel;
      end
    end
  end

  // Next scoreboard value: retire the completing write, then mark the new issue (newer issue wins)
  always_comb begin
    busy_next = busy_vec;
    if (RegWrite) busy_next[WN] = 1'b0;
    if (iss_valid && (iss_wn != 5'd0)) busy_next[iss_wn] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Pending-write scoreboard; a flush drops every pending entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
    end else if (flush) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter with write scoreboard
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid, iss_valid, flush;
  logic        a_ready, b_ready;
  logic [4:0]  a_wn, b_wn, iss_wn;
  logic [31:0] a_wd, b_wd;
  logic        RegWrite;
  logic [4:0]  WN;
  logic [31:0] WD;
  logic [31:0] busy_vec;
  logic [3:0]  starve_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];

  wb_port_arbiter #(.STARVE_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_wn(a_wn), .a_wd(a_wd),
    .b_valid(b_valid), .b_ready(b_ready), .b_wn(b_wn), .b_wd(b_wd),
    .iss_valid(iss_valid), .iss_wn(iss_wn), .flush(flush),
    .RegWrite(RegWrite), .WN(WN), .WD(WD),
    .busy_vec(busy_vec), .starve_cnt(starve_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted non-r0 writes are queued, each RegWrite pulse must match the oldest
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check("one_ready", {63'd0, a_ready & b_ready}, 64'd0);
      if (RegWrite) begin
        if (exp_q.size() == 0) begin
          check("sb_spurious_write", {59'd0, WN}, 64'd0);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          check("sb_wn", {59'd0, WN}, {59'd0, e[36:32]});
          check("sb_wd", {32'd0, WD}, {32'd0, e[31:0]});
        end
      end
      if (a_valid && a_ready && a_wn != 5'd0) exp_q.push_back({a_wn, a_wd});
      if (b_valid && b_ready && b_wn != 5'd0) exp_q.push_back({b_wn, b_wd});
    end
  end

  initial begin
    logic exp_b;
    rst_n = 1'b0; flush = 1'b0; iss_valid = 1'b0; iss_wn = 5'd0;
    a_valid = 1'b1; a_wn = 5'd5; a_wd = 32'h12345678;
    b_valid = 1'b0; b_wn = 5'd0; b_wd = 32'd0;
    #3;
    check("rst_regwrite", {63'd0, RegWrite}, 64'd0);
    check("rst_wn", {59'd0, WN}, 64'd0);
    check("rst_wd", {32'd0, WD}, 64'd0);
    check("rst_busy", {32'd0, busy_vec}, 64'd0);
    check("rst_starve", {60'd0, starve_cnt}, 64'd0);
    check("rst_a_ready", {63'd0, a_ready}, 64'd0);

    // Single A write latency
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("t1_a_ready", {63'd0, a_ready}, 64'd1);
    tick();
    a_valid = 1'b0;
    check("t1_regwrite", {63'd0, RegWrite}, 64'd1);
    check("t1_wn", {59'd0, WN}, 64'd5);
    check("t1_wd", {32'd0, WD}, 64'h12345678);
    tick();
    check("t1_regwrite_off", {63'd0, RegWrite}, 64'd0);

    // Contention from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_valid = 1'b1; a_wn = 5'd1; b_valid = 1'b1; b_wn = 5'd2; b_wd = 32'hB0B0B0B0;
    for (int i = 0; i < 6; i++) begin
      a_wd = 32'hA0000000 + i;
      #1;
`ifdef WB_RR_ARB_EN
      exp_b = (i % 2) == 1;
      check("t2_starve", {60'd0, starve_cnt}, 64'd0);
`else
      exp_b = (i == 4);
      check("t2_starve", {60'd0, starve_cnt}, (i <= 4) ? i : 0);
`endif
      check("t2_a_ready", {63'd0, a_ready}, {63'd0, ~exp_b});
      check("t2_b_ready", {63'd0, b_ready}, {63'd0, exp_b});
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    tick();

    // Scoreboard set and clear
    iss_valid = 1'b1; iss_wn = 5'd7;
    tick();
    iss_valid = 1'b0;
    check("t3_busy_set", {63'd0, busy_vec[7]}, 64'd1);
    tick();
    check("t3_busy_hold", {63'd0, busy_vec[7]}, 64'd1);
    a_valid = 1'b1; a_wn = 5'd7; a_wd = 32'h00000077;
    #1;
    check("t3_a_ready", {63'd0, a_ready}, 64'd1);
    tick();
    a_valid = 1'b0;
    check("t3_busy_pre_clr", {63'd0, busy_vec[7]}, 64'd1);
    tick();
    check("t3_busy_clr", {32'd0, busy_vec}, 64'd0);

    // Same-edge set and clear of r7: set wins
    iss_valid = 1'b1;
    tick();
    iss_valid = 1'b0;
    a_valid = 1'b1; a_wd = 32'h00000777;
    tick();
    a_valid = 1'b0;
    iss_valid = 1'b1; iss_wn = 5'd7;
    check("t3s_regwrite", {59'd0, WN, RegWrite}, {58'd0, 5'd7, 1'b1});
    tick();
    iss_valid = 1'b0;
    check("t3s_busy_kept", {32'd0, busy_vec}, 64'h80);

    // Writes and issues to r0
    a_valid = 1'b1; a_wn = 5'd0; a_wd = 32'hFFFFFFFF;
    iss_valid = 1'b1; iss_wn = 5'd0;
    #1;
    check("t4_a_ready", {63'd0, a_ready}, 64'd1);
    tick();
    a_valid = 1'b0; iss_valid = 1'b0;
    check("t4_regwrite", {63'd0, RegWrite}, 64'd0);
    check("t4_busy", {32'd0, busy_vec}, 64'h80);

    // Flush with a registered write in flight
    iss_valid = 1'b1;
    for (int r = 4; r < 7; r++) begin
      iss_wn = 5'(r);
      tick();
    end
    iss_valid = 1'b0;
    check("t5_busy_f0", {32'd0, busy_vec}, 64'hF0);
    a_valid = 1'b1; a_wn = 5'd4; a_wd = 32'h0000AAAA;
    tick();
    flush = 1'b1; a_wn = 5'd9; a_wd = 32'h00000099;
    iss_valid = 1'b1; iss_wn = 5'd3;
    #1;
    check("t5_a_ready_flush", {63'd0, a_ready}, 64'd0);
    check("t5_inflight", {59'd0, WN, RegWrite}, {58'd0, 5'd4, 1'b1});
    tick();
    flush = 1'b0; iss_valid = 1'b0;
    check("t5_busy_flushed", {32'd0, busy_vec}, 64'd0);
    check("t5_regwrite_off", {63'd0, RegWrite}, 64'd0);
    check("t5_starve", {60'd0, starve_cnt}, 64'd0);
    #1;
    check("t5_a_ready_after", {63'd0, a_ready}, 64'd1);
    tick();
    a_valid = 1'b0;
    check("t5_wn9", {59'd0, WN, RegWrite}, {58'd0, 5'd9, 1'b1});
    tick();

    // Asynchronous reset mid-cycle while a write is registered
    iss_valid = 1'b1; iss_wn = 5'd11;
    a_valid = 1'b1; a_wn = 5'd10; a_wd = 32'h0000A10A;
    b_valid = 1'b1; b_wn = 5'd12; b_wd = 32'h0000B12B;
    tick();
    iss_valid = 1'b0;
    tick();
    check("t6_pre_regwrite", {63'd0, RegWrite}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_regwrite", {63'd0, RegWrite}, 64'd0);
    check("t6_busy", {32'd0, busy_vec}, 64'd0);
    check("t6_starve", {60'd0, starve_cnt}, 64'd0);
    check("t6_readies", {62'd0, a_ready, b_ready}, 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_first_grant", {62'd0, a_ready, b_ready}, 64'd2);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("t6_first_write", {59'd0, WN, RegWrite}, {58'd0, 5'd10, 1'b1});
    tick();
    tick();
    check("sb_drain", exp_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
